// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational 8-bit ALU between N_REQ requesters. A round-robin
//   search picks a winner in IDLE. The winner's op and operands are latched,
//   drive the ALU for one cycle in EXEC, and the registered result is returned
//   with the winner's index over a valid/ready handshake in RESP. Only one
//   operation is in flight at a time.
//
// Ports
//   clk, rst_n          clock (rising edge) and async active-low reset
//   req_valid/req_ready per-requester handshake; ready is one-hot or zero
//   req_op/req_a/req_b  packed per-requester payloads (6/8/8 bits per slot)
//   alu_op/alu_a/alu_b  latched operation towards the shared ALU
//   alu_out             combinational ALU result
//   resp_valid/ready    result handshake
//   resp_id/data/err    owner index, registered result, illegal-op flag
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | searching for a requester, grant + latch payload on a hit
// ST_EXEC | latched operation on the ALU, result captured at cycle end
// ST_RESP | result presented until the consumer takes it
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*6-1:0]   req_op,
    input  logic [N_REQ*8-1:0]   req_a,
    input  logic [N_REQ*8-1:0]   req_b,
    output logic [5:0]           alu_op,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    input  logic [7:0]           alu_out,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [7:0]           resp_data,
    output logic                 resp_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ID_W-1:0]   r_rr_ptr;
    logic [5:0]        r_op;
    logic [7:0]        r_a;
    logic [7:0]        r_b;
    logic [7:0]        r_result;
    logic [ID_W-1:0]   r_id;
    logic              r_err;

    logic              w_grant_found;
    logic [ID_W-1:0]   w_grant_idx;
    logic              w_accept;
    logic              w_done;
    logic              w_op_illegal;

    // (base + k) mod N_REQ without relying on N_REQ being a power of two;
    // base < N_REQ and k < N_REQ, so a single subtraction is enough.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int              k);
        logic [31:0] s;
        s = 32'(base) + 32'(k);
        if (s >= 32'(N_REQ)) begin
            s = s - 32'(N_REQ);
        end
        return s[ID_W-1:0];
    endfunction

    // First valid requester at or after the round-robin pointer.
    always_comb begin : grant_search
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_grant_found && req_valid[wrap_idx(r_rr_ptr, k)]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = wrap_idx(r_rr_ptr, k);
            end
        end
    end

    // rst_n gates the grant so req_ready stays low while reset is held,
    // even though the state register already sits in IDLE.
    assign w_accept     = (r_state == ST_IDLE) && w_grant_found && rst_n;
    assign w_done       = (r_state == ST_RESP) && resp_ready;
    assign w_op_illegal = |r_op[5:3];

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : fsm_next
        w_state_nxt = r_state;
        req_ready   = '0;
        resp_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    req_ready[w_grant_idx] = 1'b1;
                    w_state_nxt            = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : datapath
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_id     <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op <= req_op[6*w_grant_idx +: 6];
                r_a  <= req_a[8*w_grant_idx +: 8];
                r_b  <= req_b[8*w_grant_idx +: 8];
                r_id <= w_grant_idx;
            end
            if (r_state == ST_EXEC) begin
                // Ops outside the ALU's defined range return zero data.
                r_err    <= w_op_illegal;
                r_result <= w_op_illegal ? 8'h00 : alu_out;
            end
            // The winner becomes lowest priority once its result is taken.
            if (w_done) begin
                r_rr_ptr <= (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + 1'b1;
            end
        end
    end

    assign alu_op    = r_op;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign resp_id   = r_id;
    assign resp_data = r_result;
    assign resp_err  = r_err;

endmodule
